// File: rtl/bat_gauge_vga.sv
// bat_gauge_vga
//   Receives the CPU battery code bat_ctl[4:0] ({charging, level[3:0]}) from
//   another clock domain. The code is synchronised and debounced, then drawn
//   as a 10-segment battery gauge on a 640x480 VGA raster.
//   The pending code is applied only at frame_start, so a frame never tears.
//   Optional feature: define BAT_GAUGE_BLINK_EN to blink the outline and the
//   lit segments at low level while not charging.
module bat_gauge_vga #(
  parameter int CLK_DIV       = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int BOX_X         = 240,
  parameter int BOX_Y         = 208,
  parameter int SEG_W         = 14,
  parameter int SEG_H         = 60,
  parameter int SEG_GAP       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] bat_ctl,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       frame_start,
  output logic [3:0] level_q
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  // Gauge geometry: 2 px outline, a gap, then 10 segments separated by gaps.
  localparam int NSEG    = 10;
  localparam int PITCH   = SEG_W + SEG_GAP;
  localparam int BOX_W   = NSEG * PITCH + SEG_GAP + 4;
  localparam int BOX_H   = SEG_H + 2 * SEG_GAP + 4;
  localparam int SEG_X0  = BOX_X + 2 + SEG_GAP;
  localparam int SEG_Y0  = BOX_Y + 2 + SEG_GAP;
  localparam int NUB_W   = 6;
  localparam int NUB_H   = SEG_H / 2;
  localparam int NUB_X   = BOX_X + BOX_W;
  localparam int NUB_Y   = BOX_Y + (BOX_H - NUB_H) / 2;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_FS     = VW'(V_ACTIVE);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] CYAN   = 12'h0FF;
  localparam logic [11:0] RED    = 12'hF00;
  localparam logic [11:0] YELLOW = 12'hFF0;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] GREY   = 12'h222;
  localparam logic [11:0] BLACK  = 12'h000;

  // Levels above the segment count are shown as full.
  function automatic logic [3:0] clamp_level(input logic [3:0] lvl);
    return (lvl > 4'd10) ? 4'd10 : lvl;
  endfunction

  // Colour of a lit segment for the displayed state.
  function automatic logic [11:0] lit_colour(input logic chg, input logic [3:0] lvl);
    logic [11:0] c;
    if (chg)               c = CYAN;
    else if (lvl <= 4'd2)  c = RED;
    else if (lvl <= 4'd5)  c = YELLOW;
    else                   c = GREEN;
    return c;
  endfunction

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;
  logic [4:0]    sync1_q, sync1_d;
  logic [4:0]    sync2_q, sync2_d;
  logic [4:0]    prev_q, prev_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic [4:0]    pend_q, pend_d;
  logic [3:0]    level_d;
  logic          charging_q, charging_d;
  logic          tick;
  logic          blank;

  int            px, py;
  logic          active, in_box, outline, nub, seg_row, seg_hit, seg_lit;
  logic [11:0]   pix;

  assign tick        = (div_q == DIV_LAST);
  assign frame_start = tick && (h_cnt_q == '0) && (v_cnt_q == V_FS);

`ifdef BAT_GAUGE_BLINK_EN
  logic [4:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps once per frame; bit 4 gives a ~32-frame blink period.
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + 5'd1 : frame_cnt_q;
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_cnt_q <= '0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign blank = !charging_q && (level_q <= 4'd2) && frame_cnt_q[4];
`else
  assign blank = 1'b0;
`endif

  // Pixel divider and raster counters; counters move only on a pixel tick.
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Input path: 2-flop synchroniser, then a stability counter that must
  // saturate before the sample is accepted into pend.
  always_comb begin
    sync1_d    = bat_ctl;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    if (sync2_q != prev_q)          stab_cnt_d = '0;
    else if (stab_cnt_q == STAB_MAX) stab_cnt_d = stab_cnt_q;
    else                            stab_cnt_d = stab_cnt_q + 1'b1;
    pend_d     = (stab_cnt_q == STAB_MAX) ? prev_q : pend_q;
  end

  // Displayed state changes only at frame_start; the pend value registered
  // before this edge is the one taken.
  always_comb begin
    level_d    = frame_start ? clamp_level(pend_q[3:0]) : level_q;
    charging_d = frame_start ? pend_q[4] : charging_q;
  end

  // Pixel renderer: syncs and colour come from the same counter values, so
  // they are registered together with one tick of latency.
  always_comb begin
    px      = int'(h_cnt_q);
    py      = int'(v_cnt_q);
    active  = (px < H_ACTIVE) && (py < V_ACTIVE);
    in_box  = (px >= BOX_X) && (px < BOX_X + BOX_W) &&
              (py >= BOX_Y) && (py < BOX_Y + BOX_H);
    outline = in_box && ((px < BOX_X + 2) || (px >= BOX_X + BOX_W - 2) ||
                         (py < BOX_Y + 2) || (py >= BOX_Y + BOX_H - 2));
    nub     = (px >= NUB_X) && (px < NUB_X + NUB_W) &&
              (py >= NUB_Y) && (py < NUB_Y + NUB_H);
    seg_row = (py >= SEG_Y0) && (py < SEG_Y0 + SEG_H);
    seg_hit = 1'b0;
    seg_lit = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if (seg_row && (px >= SEG_X0 + i * PITCH) && (px < SEG_X0 + i * PITCH + SEG_W)) begin
        seg_hit = 1'b1;
        seg_lit = (i < int'(level_q));
      end
    end

    pix = BLACK;
    if (!active)      pix = BLACK;
    else if (outline) pix = blank ? BLACK : WHITE;
    else if (nub)     pix = WHITE;
    else if (seg_hit) pix = seg_lit ? (blank ? BLACK : lit_colour(charging_q, level_q)) : GREY;

    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (tick) begin
      hsync_d = !((px >= H_ACTIVE + H_FP) && (px < H_ACTIVE + H_FP + H_SYNC));
      vsync_d = !((py >= V_ACTIVE + V_FP) && (py < V_ACTIVE + V_FP + V_SYNC));
      rgb_d   = pix;
    end
  end

  // State registers; reset returns the raster to (0,0) with syncs high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q      <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      stab_cnt_q <= '0;
      pend_q     <= '0;
      level_q    <= '0;
      charging_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      stab_cnt_q <= stab_cnt_d;
      pend_q     <= pend_d;
      level_q    <= level_d;
      charging_q <= charging_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign vga_r = rgb_q[11:8];
  assign vga_g = rgb_q[7:4];
  assign vga_b = rgb_q[3:0];

endmodule

// File: tb/tb_bat_gauge_vga.sv
// Self-checking bench for bat_gauge_vga on a shrunken raster so that many
// frames fit in a short run. Expected gauge states are queued when a code is
// driven and take effect at the next frame_start seen from the DUT.
module tb_bat_gauge_vga;

  localparam int CD  = 2;
  localparam int HA  = 72, HF = 4, HS = 8, HB = 4;
  localparam int VA  = 16, VF = 2, VS = 2, VB = 2;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int BX  = 4, BY = 2;
  localparam int SWD = 4, SHT = 6, SG = 1;
  localparam int BW  = 10 * (SWD + SG) + SG + 4;
  localparam int BH  = SHT + 2 * SG + 4;
  localparam int PY  = BY + BH / 2;
  localparam int FRAME_PIX = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] bat_ctl;
  logic       hsync, vsync, frame_start;
  logic [3:0] vga_r, vga_g, vga_b, level_q;

  bat_gauge_vga #(
    .CLK_DIV(CD), .STABLE_CYCLES(16),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BOX_X(BX), .BOX_Y(BY), .SEG_W(SWD), .SEG_H(SHT), .SEG_GAP(SG)
  ) dut (
    .clk(clk), .rst(rst), .bat_ctl(bat_ctl),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .level_q(level_q)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic chg; logic [3:0] lvl; } disp_t;

  disp_t exp_q[$];
  disp_t disp;
  int    n_chk  = 0;
  int    n_fail = 0;
  int    ecnt   = 0;
  int    hs_req = 0;
  int    hs_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clampf(input logic [3:0] l);
    return (l > 4'd10) ? 10 : int'(l);
  endfunction

  function automatic logic [11:0] seg_col(input int i, input disp_t d);
    int l;
    l = clampf(d.lvl);
    if (i >= l)  return 12'h222;
    if (d.chg)   return 12'h0FF;
    if (l <= 2)  return 12'hF00;
    if (l <= 5)  return 12'hFF0;
    return 12'h0F0;
  endfunction

  // Returns {valid, colour} for the probe points of a frame.
  function automatic logic [12:0] probe(input int h, input int v, input disp_t d);
    if (v == PY) begin
      if (h == BX || h == BX + BW - 1 || h == BX + BW + 2) return {1'b1, 12'hFFF};
      if (h == BX + 2 || h == BX + 2 + SG + SWD || h == BX + BW + 8 || h == HA + 2)
        return {1'b1, 12'h000};
      for (int i = 0; i < 10; i++)
        if (h == BX + 2 + SG + i * (SWD + SG) + 1) return {1'b1, seg_col(i, d)};
    end
    if ((v == BY || v == BY + BH - 1) && h == BX + 26) return {1'b1, 12'hFFF};
    if ((v == 0 || v == VA - 1) && h == BX + 26) return {1'b1, 12'h000};
    return 13'h0;
  endfunction

  // Edge count since reset release; the bench's own raster reference.
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt = 0;
    else     ecnt = ecnt + 1;
  end

  logic hs_prev, vs_prev, lvl_chk;
  int   last_hs_e, last_fs_e, vs_fall_e, hs_ints, fs_ints, vs_ints;
  logic [12:0] pr;
  int   p, h, v;

  initial begin
    hs_ints = 0; fs_ints = 0; vs_ints = 0;
  end

  // Monitor: timing intervals, frame_start, level updates and pixel probes.
  always @(negedge clk) begin
    if (rst) begin
      hs_prev = 1'b1; vs_prev = 1'b1; lvl_chk = 1'b0;
      last_hs_e = -1; last_fs_e = -1; vs_fall_e = -1;
      disp = '0;
      exp_q.delete();
    end else begin
      if (lvl_chk) begin
        chk("level_q", level_q, clampf(disp.lvl));
        chk("fs_width", frame_start, 0);
        lvl_chk = 1'b0;
      end
      if (frame_start) begin
        if (last_fs_e < 0) chk("fs_first", ecnt, VA * HT * CD + CD - 1);
        else if (fs_ints < 3) begin
          chk("fs_period", ecnt - last_fs_e, FRAME_PIX * CD);
          fs_ints++;
        end
        last_fs_e = ecnt;
        if (exp_q.size() > 0) begin
          disp = exp_q[$];
          exp_q.delete();
        end
        lvl_chk = 1'b1;
      end
      if (hs_prev && !hsync) begin
        if (hs_done != hs_req) begin
          chk("hs_first", (ecnt >= (HA + HF) * CD) && (ecnt <= (HA + HF + 1) * CD), 1);
          hs_done = hs_req;
        end else if (hs_ints < 4 && last_hs_e >= 0) begin
          chk("hs_period", ecnt - last_hs_e, HT * CD);
          hs_ints++;
        end
        last_hs_e = ecnt;
      end
      hs_prev = hsync;
      if (vs_prev && !vsync) vs_fall_e = ecnt;
      if (!vs_prev && vsync && vs_fall_e >= 0 && vs_ints < 2) begin
        chk("vs_low", ecnt - vs_fall_e, VS * HT * CD);
        vs_ints++;
      end
      vs_prev = vsync;
      if (ecnt >= CD && (ecnt % CD) == 0) begin
        p  = ecnt / CD - 1;
        h  = p % HT;
        v  = (p / HT) % VT;
        pr = probe(h, v, disp);
        if (pr[12]) chk($sformatf("pix_%0d_%0d", h, v), {vga_r, vga_g, vga_b}, pr[11:0]);
      end
    end
  end

  // Wait until the start of the given line of the given frame (bench raster).
  task automatic wait_at(input int frame, input int line);
    int target, guard;
    target = CD * (frame * FRAME_PIX + line * HT + 1);
    guard  = 0;
    while (ecnt < target && guard < 4 * FRAME_PIX * CD) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_at", ecnt >= target, 1);
  endtask

  // Drive a code mid-frame, let it settle, then queue its expected display.
  task automatic step(input int frame, input logic [4:0] code);
    disp_t e;
    wait_at(frame, 2);
    bat_ctl = code;
    repeat (100) @(negedge clk);
    e.chg = code[4];
    e.lvl = code[3:0];
    exp_q.push_back(e);
  endtask

  initial begin
    int guard;
    rst     = 1'b1;
    bat_ctl = 5'b00000;
    repeat (3) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_level", level_q, 0);
    chk("rst_fs", frame_start, 0);
    hs_req = 1;
    rst    = 1'b0;

    step(1, 5'b00111);
    step(2, 5'b01111);
    step(3, 5'b00010);
    step(4, 5'b10100);
    wait_at(5, 2);
    bat_ctl = 5'b00000;
    repeat (10) @(negedge clk);
    bat_ctl = 5'b10100;
    step(6, 5'b00000);
    step(7, 5'b00101);

    // Reset in the middle of the frame showing level 5.
    wait_at(8, 8);
    repeat (40) @(negedge clk);
    chk("pre_rst_level", level_q, 5);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_hsync", hsync, 1);
    chk("mid_rst_vsync", vsync, 1);
    chk("mid_rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("mid_rst_level", level_q, 0);
    repeat (3) @(negedge clk);
    hs_req = 2;
    rst    = 1'b0;
    guard  = 0;
    while (hs_done != hs_req && guard < 2 * HT * CD) begin
      @(negedge clk);
      guard++;
    end
    chk("hs_after_rst_seen", hs_done, hs_req);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
